// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Operands can optionally be two's complement; they are then converted as
// sign plus magnitude. The digits, sign and overflow flag are registered
// and held until the next conversion completes.
module bin_to_bcd_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGITS      = 5,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   A_input,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic                    sign,
  output logic                    overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Reject unsupported parameter sets while elaborating.
  generate
    if ((DATA_WIDTH < 2) || (DATA_WIDTH > 32) || (DIGITS < 1)) begin : g_param_err
      $error("bin_to_bcd_seq: DATA_WIDTH must be 2..32 and DIGITS >= 1");
    end
  endgenerate

  logic [1:0]            state_r;
  logic [DATA_WIDTH-1:0] mag_r;
  logic [BW-1:0]         dig_r;
  logic [CW-1:0]         cnt_r;
  logic                  ovf_r;
  logic                  sign_r;

  logic                  neg_s;
  logic [DATA_WIDTH-1:0] load_mag_s;
  logic [BW-1:0]         adj_s;
  logic [BW-1:0]         shift_dig_s;
  logic                  shift_out_s;

  // Operand capture: negative operands (signed mode only) become their
  // magnitude as an unsigned DATA_WIDTH-bit value, so the most negative
  // operand maps onto 2^(DATA_WIDTH-1) without wrapping.
  always_comb begin
    neg_s = (SIGNED_MODE == 1'b1) && A_input[DATA_WIDTH-1];
    if (neg_s) begin
      load_mag_s = (~A_input) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      load_mag_s = A_input;
    end
  end

  // Add 3 to every working digit that is 5 or more, then form the shifted
  // digit vector; the bit leaving the top digit signals overflow.
  always_comb begin
    adj_s = dig_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_r[4*k +: 4] >= 4'd5) begin
        adj_s[4*k +: 4] = dig_r[4*k +: 4] + 4'd3;
      end else begin
        adj_s[4*k +: 4] = dig_r[4*k +: 4];
      end
    end
    shift_dig_s = {adj_s[BW-2:0], mag_r[DATA_WIDTH-1]};
    shift_out_s = adj_s[BW-1];
  end

  // Control FSM plus working datapath and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      mag_r    <= {DATA_WIDTH{1'b0}};
      dig_r    <= {BW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      sign_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= {BW{1'b0}};
      sign     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mag_r   <= load_mag_s;
            sign_r  <= neg_s;
            dig_r   <= {BW{1'b0}};
            ovf_r   <= 1'b0;
            cnt_r   <= CW'(DATA_WIDTH);
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          dig_r <= shift_dig_s;
          mag_r <= {mag_r[DATA_WIDTH-2:0], 1'b0};
          ovf_r <= ovf_r | shift_out_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            // Last shift: publish the post-shift result.
            bcd_out  <= shift_dig_s;
            sign     <= sign_r;
            overflow <= ovf_r | shift_out_s;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_r  <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
